// File: rtl/stg_mem_if.sv
// stg_mem_if: data-memory request/acknowledge bus between stg_mem and the data memory.
// master = pipeline stage (issues requests), slave = memory (acknowledges).

`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif

interface stg_mem_if;
  logic                  req;
  logic                  we;
  logic [`SIZE_ADDR-1:0] addr;
  logic [`SIZE_DATA-1:0] wdata;
  logic                  ack;
  logic [`SIZE_DATA-1:0] rdata;

  modport master (
    output req,
    output we,
    output addr,
    output wdata,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  we,
    input  addr,
    input  wdata,
    output ack,
    output rdata
  );
endinterface

// File: rtl/stg_mem.sv
// stg_mem: amber pipeline stage 5 (memory access).
// Registers the execute bundle; loads/stores run a req/ack transaction on mem_if while
// ow_stall holds upstream. Writeback sees bubbles (all *_we low) whenever nothing completes.
// Optional feature: define AMBER_MEM_TIMEOUT_EN to abort a transaction after TIMEOUT_CYCLES
// wait cycles without ack (ow_mem_fault pulses, bundle emitted with all *_we forced low).

`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 8
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif
`ifndef SIZE_TGT_AR
`define SIZE_TGT_AR 2
`endif

module stg_mem #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                    iw_clk,
  input  logic                    iw_rst_n,
  input  logic                    iw_valid,
  input  logic [`SIZE_ADDR-1:0]   iw_pc,
  input  logic [`SIZE_DATA-1:0]   iw_instr,
  input  logic [`SIZE_OPC-1:0]    iw_opc,
  input  logic [`SIZE_TGT_GP-1:0] iw_tgt_gp,
  input  logic                    iw_tgt_gp_we,
  input  logic [`SIZE_TGT_SR-1:0] iw_tgt_sr,
  input  logic                    iw_tgt_sr_we,
  input  logic [`SIZE_TGT_AR-1:0] iw_tgt_ar,
  input  logic                    iw_tgt_ar_we,
  input  logic [`SIZE_DATA-1:0]   iw_result,
  input  logic [`SIZE_ADDR-1:0]   iw_ar_result,
  input  logic                    iw_mem_rd,
  input  logic                    iw_mem_wr,
  input  logic [`SIZE_ADDR-1:0]   iw_mem_addr,
  input  logic [`SIZE_DATA-1:0]   iw_mem_wdata,
  output logic                    ow_stall,
  stg_mem_if.master               mem_if,
  output logic [`SIZE_ADDR-1:0]   ow_pc,
  output logic [`SIZE_DATA-1:0]   ow_instr,
  output logic [`SIZE_OPC-1:0]    ow_opc,
  output logic [`SIZE_TGT_GP-1:0] ow_tgt_gp,
  output logic                    ow_tgt_gp_we,
  output logic [`SIZE_TGT_SR-1:0] ow_tgt_sr,
  output logic                    ow_tgt_sr_we,
  output logic [`SIZE_TGT_AR-1:0] ow_tgt_ar,
  output logic                    ow_tgt_ar_we,
  output logic [`SIZE_DATA-1:0]   ow_result,
  output logic [`SIZE_ADDR-1:0]   ow_ar_result,
  output logic                    ow_mem_fault
);

  // A zero timeout would abort before the memory could ever answer.
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("stg_mem: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  typedef struct packed {
    logic [`SIZE_ADDR-1:0]   pc;
    logic [`SIZE_DATA-1:0]   instr;
    logic [`SIZE_OPC-1:0]    opc;
    logic [`SIZE_TGT_GP-1:0] tgt_gp;
    logic                    tgt_gp_we;
    logic [`SIZE_TGT_SR-1:0] tgt_sr;
    logic                    tgt_sr_we;
    logic [`SIZE_TGT_AR-1:0] tgt_ar;
    logic                    tgt_ar_we;
    logic [`SIZE_DATA-1:0]   result;
    logic [`SIZE_ADDR-1:0]   ar_result;
  } bundle_t;

  // Turn a bundle into a bubble: fields kept, all write-enables cleared.
  function automatic bundle_t kill_we(input bundle_t b);
    bundle_t r;
    r           = b;
    r.tgt_gp_we = 1'b0;
    r.tgt_sr_we = 1'b0;
    r.tgt_ar_we = 1'b0;
    return r;
  endfunction

  state_e                state_q, state_d;
  bundle_t               in_b;
  bundle_t               out_q, out_d;
  bundle_t               hold_q, hold_d;
  logic                  hold_load_q, hold_load_d;
  logic                  req_q, req_d;
  logic                  we_q, we_d;
  logic [`SIZE_ADDR-1:0] addr_q, addr_d;
  logic [`SIZE_DATA-1:0] wdata_q, wdata_d;
  logic                  fault_q, fault_d;
  logic                  accept_mem;
  logic                  expire;

  assign in_b = '{
    pc:        iw_pc,
    instr:     iw_instr,
    opc:       iw_opc,
    tgt_gp:    iw_tgt_gp,
    tgt_gp_we: iw_tgt_gp_we,
    tgt_sr:    iw_tgt_sr,
    tgt_sr_we: iw_tgt_sr_we,
    tgt_ar:    iw_tgt_ar,
    tgt_ar_we: iw_tgt_ar_we,
    result:    iw_result,
    ar_result: iw_ar_result
  };

  assign accept_mem = (state_q == StIdle) && iw_valid && (iw_mem_rd || iw_mem_wr);

`ifdef AMBER_MEM_TIMEOUT_EN
  localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                 $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Expiry fires on the wait cycle that would bring the count up to TIMEOUT_CYCLES.
  assign expire = (state_q == StBusy) && !mem_if.ack &&
                  (cnt_q == CntW'(TIMEOUT_CYCLES - 1));
`else
  assign expire = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; ack has priority over timeout expiry.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept_mem) state_d = StBusy;
      StBusy: if (mem_if.ack || expire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Next-state values for the output bundle, hold registers and memory request.
  always_comb begin
    out_d       = kill_we(out_q);
    hold_d      = hold_q;
    hold_load_d = hold_load_q;
    req_d       = req_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    fault_d     = 1'b0;
`ifdef AMBER_MEM_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (iw_valid) begin
          if (iw_mem_rd || iw_mem_wr) begin
            hold_d      = in_b;
            // rd+wr together is a store, so only a pure read loads rdata.
            hold_load_d = iw_mem_rd && !iw_mem_wr;
            req_d       = 1'b1;
            we_d        = iw_mem_wr;
            addr_d      = iw_mem_addr;
            wdata_d     = iw_mem_wdata;
`ifdef AMBER_MEM_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end else begin
            out_d = in_b;
          end
        end
      end
      StBusy: begin
        if (mem_if.ack) begin
          req_d = 1'b0;
          out_d = hold_q;
          if (hold_load_q) out_d.result = mem_if.rdata;
        end else if (expire) begin
          req_d   = 1'b0;
          out_d   = kill_we(hold_q);
          fault_d = 1'b1;
        end else begin
`ifdef AMBER_MEM_TIMEOUT_EN
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: ;
    endcase
  end

  // Datapath registers; reset clears every output, dropping any request in flight.
  always_ff @(posedge iw_clk or negedge iw_rst_n) begin
    if (!iw_rst_n) begin
      out_q       <= '0;
      hold_q      <= '0;
      hold_load_q <= 1'b0;
      req_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      fault_q     <= 1'b0;
`ifdef AMBER_MEM_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      out_q       <= out_d;
      hold_q      <= hold_d;
      hold_load_q <= hold_load_d;
      req_q       <= req_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      fault_q     <= fault_d;
`ifdef AMBER_MEM_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign ow_stall      = (state_q == StBusy);
  assign mem_if.req    = req_q;
  assign mem_if.we     = we_q;
  assign mem_if.addr   = addr_q;
  assign mem_if.wdata  = wdata_q;

  assign ow_pc         = out_q.pc;
  assign ow_instr      = out_q.instr;
  assign ow_opc        = out_q.opc;
  assign ow_tgt_gp     = out_q.tgt_gp;
  assign ow_tgt_gp_we  = out_q.tgt_gp_we;
  assign ow_tgt_sr     = out_q.tgt_sr;
  assign ow_tgt_sr_we  = out_q.tgt_sr_we;
  assign ow_tgt_ar     = out_q.tgt_ar;
  assign ow_tgt_ar_we  = out_q.tgt_ar_we;
  assign ow_result     = out_q.result;
  assign ow_ar_result  = out_q.ar_result;

`ifdef AMBER_MEM_TIMEOUT_EN
  assign ow_mem_fault  = fault_q;
`else
  assign ow_mem_fault  = 1'b0;
  logic unused_fault;
  assign unused_fault  = fault_q;
`endif

endmodule

// File: tb/tb_stg_mem.sv
// tb_stg_mem: directed self-checking bench for stg_mem.
// With AMBER_MEM_TIMEOUT_EN defined it also exercises the timeout abort (TIMEOUT_CYCLES=4).

`ifndef SIZE_ADDR
`define SIZE_ADDR 24
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 24
`endif
`ifndef SIZE_OPC
`define SIZE_OPC 8
`endif
`ifndef SIZE_TGT_GP
`define SIZE_TGT_GP 4
`endif
`ifndef SIZE_TGT_SR
`define SIZE_TGT_SR 2
`endif
`ifndef SIZE_TGT_AR
`define SIZE_TGT_AR 2
`endif

module tb_stg_mem;

  logic                    clk;
  logic                    rst_n;
  logic                    valid;
  logic [`SIZE_ADDR-1:0]   pc;
  logic [`SIZE_DATA-1:0]   instr;
  logic [`SIZE_OPC-1:0]    opc;
  logic [`SIZE_TGT_GP-1:0] tgt_gp;
  logic                    tgt_gp_we;
  logic [`SIZE_TGT_SR-1:0] tgt_sr;
  logic                    tgt_sr_we;
  logic [`SIZE_TGT_AR-1:0] tgt_ar;
  logic                    tgt_ar_we;
  logic [`SIZE_DATA-1:0]   result;
  logic [`SIZE_ADDR-1:0]   ar_result;
  logic                    mem_rd;
  logic                    mem_wr;
  logic [`SIZE_ADDR-1:0]   mem_addr;
  logic [`SIZE_DATA-1:0]   mem_wdata;

  logic                    o_stall;
  logic [`SIZE_ADDR-1:0]   o_pc;
  logic [`SIZE_DATA-1:0]   o_instr;
  logic [`SIZE_OPC-1:0]    o_opc;
  logic [`SIZE_TGT_GP-1:0] o_tgt_gp;
  logic                    o_tgt_gp_we;
  logic [`SIZE_TGT_SR-1:0] o_tgt_sr;
  logic                    o_tgt_sr_we;
  logic [`SIZE_TGT_AR-1:0] o_tgt_ar;
  logic                    o_tgt_ar_we;
  logic [`SIZE_DATA-1:0]   o_result;
  logic [`SIZE_ADDR-1:0]   o_ar_result;
  logic                    o_fault;

  int n_checks = 0;
  int n_errors = 0;

  stg_mem_if mem_if ();

  stg_mem #(
    .TIMEOUT_CYCLES (4)
  ) u_dut (
    .iw_clk       (clk),
    .iw_rst_n     (rst_n),
    .iw_valid     (valid),
    .iw_pc        (pc),
    .iw_instr     (instr),
    .iw_opc       (opc),
    .iw_tgt_gp    (tgt_gp),
    .iw_tgt_gp_we (tgt_gp_we),
    .iw_tgt_sr    (tgt_sr),
    .iw_tgt_sr_we (tgt_sr_we),
    .iw_tgt_ar    (tgt_ar),
    .iw_tgt_ar_we (tgt_ar_we),
    .iw_result    (result),
    .iw_ar_result (ar_result),
    .iw_mem_rd    (mem_rd),
    .iw_mem_wr    (mem_wr),
    .iw_mem_addr  (mem_addr),
    .iw_mem_wdata (mem_wdata),
    .ow_stall     (o_stall),
    .mem_if       (mem_if),
    .ow_pc        (o_pc),
    .ow_instr     (o_instr),
    .ow_opc       (o_opc),
    .ow_tgt_gp    (o_tgt_gp),
    .ow_tgt_gp_we (o_tgt_gp_we),
    .ow_tgt_sr    (o_tgt_sr),
    .ow_tgt_sr_we (o_tgt_sr_we),
    .ow_tgt_ar    (o_tgt_ar),
    .ow_tgt_ar_we (o_tgt_ar_we),
    .ow_result    (o_result),
    .ow_ar_result (o_ar_result),
    .ow_mem_fault (o_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction; secondary fields derive from pc so they can be checked.
  task automatic drive(input logic v, input logic rd, input logic wr,
                       input logic [23:0] p, input logic [23:0] res,
                       input logic [23:0] a, input logic [23:0] wd, input logic gpwe);
    valid     = v;
    mem_rd    = rd;
    mem_wr    = wr;
    pc        = p;
    instr     = p ^ 24'h00F0F0;
    opc       = p[7:0];
    tgt_gp    = p[5:2];
    tgt_gp_we = gpwe;
    result    = res;
    mem_addr  = a;
    mem_wdata = wd;
  endtask

  initial begin
    rst_n      = 1'b0;
    tgt_sr     = '0;
    tgt_sr_we  = 1'b0;
    tgt_ar     = '0;
    tgt_ar_we  = 1'b0;
    ar_result  = '0;
    mem_if.ack   = 1'b0;
    mem_if.rdata = '0;
    drive(1'b1, 1'b0, 1'b0, 24'h000010, 24'h000111, 24'h0, 24'h0, 1'b1);

    // Reset held with a valid instruction present.
    repeat (3) tick();
    check_eq("rst_pc", o_pc, 0);
    check_eq("rst_instr", o_instr, 0);
    check_eq("rst_opc", o_opc, 0);
    check_eq("rst_tgt_gp", o_tgt_gp, 0);
    check_eq("rst_gp_we", o_tgt_gp_we, 0);
    check_eq("rst_sr_we", o_tgt_sr_we, 0);
    check_eq("rst_ar_we", o_tgt_ar_we, 0);
    check_eq("rst_result", o_result, 0);
    check_eq("rst_ar_result", o_ar_result, 0);
    check_eq("rst_req", mem_if.req, 0);
    check_eq("rst_we", mem_if.we, 0);
    check_eq("rst_addr", mem_if.addr, 0);
    check_eq("rst_wdata", mem_if.wdata, 0);
    check_eq("rst_stall", o_stall, 0);
    check_eq("rst_fault", o_fault, 0);

    // First ALU instruction after release, one cycle later.
    rst_n = 1'b1;
    tick();
    check_eq("first_result", o_result, 24'h000111);
    check_eq("first_gp_we", o_tgt_gp_we, 1);
    check_eq("first_pc", o_pc, 24'h000010);
    check_eq("first_instr", o_instr, 24'h00F0E0);
    check_eq("first_stall", o_stall, 0);

    // Back-to-back ALU stream.
    drive(1'b1, 1'b0, 1'b0, 24'h000020, 24'h000011, 24'h0, 24'h0, 1'b1);
    tgt_sr = 2'd2; tgt_sr_we = 1'b1;
    tick();
    check_eq("alu0_result", o_result, 24'h000011);
    check_eq("alu0_sr", {o_tgt_sr, o_tgt_sr_we}, {2'd2, 1'b1});
    check_eq("alu0_tgt_gp", o_tgt_gp, 4'h8);
    check_eq("alu0_stall", o_stall, 0);
    tgt_sr_we = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 24'h000024, 24'h000022, 24'h0, 24'h0, 1'b1);
    tick();
    check_eq("alu1_result", o_result, 24'h000022);
    check_eq("alu1_pc", o_pc, 24'h000024);
    check_eq("alu1_sr_we", o_tgt_sr_we, 0);
    check_eq("alu1_stall", o_stall, 0);
    drive(1'b1, 1'b0, 1'b0, 24'h000028, 24'h000033, 24'h0, 24'h0, 1'b1);
    tgt_ar = 2'd1; tgt_ar_we = 1'b1; ar_result = 24'h123456;
    tick();
    check_eq("alu2_result", o_result, 24'h000033);
    check_eq("alu2_gp_we", o_tgt_gp_we, 1);
    check_eq("alu2_ar", {o_tgt_ar, o_tgt_ar_we}, {2'd1, 1'b1});
    check_eq("alu2_ar_result", o_ar_result, 24'h123456);
    check_eq("alu2_stall", o_stall, 0);
    tgt_ar_we = 1'b0;

    // Idle bubble: enables drop, fields hold.
    valid = 1'b0;
    tick();
    check_eq("bub_gp_we", o_tgt_gp_we, 0);
    check_eq("bub_ar_we", o_tgt_ar_we, 0);
    check_eq("bub_result", o_result, 24'h000033);

    // Load with ack three cycles after accept.
    drive(1'b1, 1'b1, 1'b0, 24'h000030, 24'h000999, 24'h000200, 24'h0, 1'b1);
    tick();
    check_eq("ld_req", mem_if.req, 1);
    check_eq("ld_we", mem_if.we, 0);
    check_eq("ld_addr", mem_if.addr, 24'h000200);
    check_eq("ld_stall", o_stall, 1);
    check_eq("ld_gp_we", o_tgt_gp_we, 0);
    // Upstream changes while busy must be ignored.
    drive(1'b1, 1'b0, 1'b0, 24'h000040, 24'h000777, 24'h000300, 24'h000001, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("ld_wait_req", mem_if.req, 1);
      check_eq("ld_wait_stall", o_stall, 1);
      check_eq("ld_wait_gp_we", o_tgt_gp_we, 0);
      check_eq("ld_wait_addr", mem_if.addr, 24'h000200);
    end
    mem_if.ack = 1'b1; mem_if.rdata = 24'hABCDEF;
    tick();
    check_eq("ld_result", o_result, 24'hABCDEF);
    check_eq("ld_done_gp_we", o_tgt_gp_we, 1);
    check_eq("ld_done_pc", o_pc, 24'h000030);
    check_eq("ld_done_tgt_gp", o_tgt_gp, 4'hC);
    check_eq("ld_done_req", mem_if.req, 0);
    check_eq("ld_done_stall", o_stall, 0);
    mem_if.ack = 1'b0;
    tick();
    check_eq("post_ld_result", o_result, 24'h000777);
    check_eq("post_ld_pc", o_pc, 24'h000040);

    // rd+wr together: a store, result passes through unchanged.
    drive(1'b1, 1'b1, 1'b1, 24'h000050, 24'h424242, 24'h000100, 24'h5A5A5A, 1'b1);
    tick();
    check_eq("st_req", mem_if.req, 1);
    check_eq("st_we", mem_if.we, 1);
    check_eq("st_addr", mem_if.addr, 24'h000100);
    check_eq("st_wdata", mem_if.wdata, 24'h5A5A5A);
    check_eq("st_gp_we", o_tgt_gp_we, 0);
    drive(1'b1, 1'b0, 1'b0, 24'h000060, 24'h000001, 24'h000002, 24'h000003, 1'b0);
    mem_if.ack = 1'b1; mem_if.rdata = 24'hFFFFFF;
    tick();
    check_eq("st_result", o_result, 24'h424242);
    check_eq("st_done_pc", o_pc, 24'h000050);
    check_eq("st_done_gp_we", o_tgt_gp_we, 1);
    check_eq("st_done_req", mem_if.req, 0);

    // Ack while idle is ignored.
    valid = 1'b0;
    tick();
    check_eq("idle_ack_req", mem_if.req, 0);
    check_eq("idle_ack_stall", o_stall, 0);
    check_eq("idle_ack_gp_we", o_tgt_gp_we, 0);
    check_eq("idle_ack_result", o_result, 24'h424242);
    mem_if.ack = 1'b0;

    // Long wait without ack.
    drive(1'b1, 1'b1, 1'b0, 24'h000070, 24'h000888, 24'h000400, 24'h0, 1'b1);
    tick();
    check_eq("lw_req", mem_if.req, 1);
`ifdef AMBER_MEM_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("to_wait_req", mem_if.req, 1);
      check_eq("to_wait_fault", o_fault, 0);
    end
    tick();
    check_eq("to_fault", o_fault, 1);
    check_eq("to_gp_we", o_tgt_gp_we, 0);
    check_eq("to_req", mem_if.req, 0);
    check_eq("to_stall", o_stall, 0);
    check_eq("to_pc", o_pc, 24'h000070);
    drive(1'b1, 1'b0, 1'b0, 24'h000080, 24'h000055, 24'h0, 24'h0, 1'b1);
    tick();
    check_eq("to_after_fault", o_fault, 0);
    check_eq("to_after_result", o_result, 24'h000055);
    check_eq("to_after_gp_we", o_tgt_gp_we, 1);
`else
    repeat (6) tick();
    check_eq("lw_wait_req", mem_if.req, 1);
    check_eq("lw_wait_stall", o_stall, 1);
    check_eq("lw_wait_fault", o_fault, 0);
    check_eq("lw_wait_addr", mem_if.addr, 24'h000400);
    mem_if.ack = 1'b1; mem_if.rdata = 24'h0F0F0F;
    tick();
    check_eq("lw_result", o_result, 24'h0F0F0F);
    check_eq("lw_fault", o_fault, 0);
    mem_if.ack = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 24'h000080, 24'h000055, 24'h0, 24'h0, 1'b1);
    tick();
    check_eq("lw_after_result", o_result, 24'h000055);
`endif

    // Reset during a transaction drops the request without a clock edge.
    drive(1'b1, 1'b1, 1'b0, 24'h000090, 24'h000AAA, 24'h000500, 24'h0, 1'b1);
    tick();
    check_eq("mr_req", mem_if.req, 1);
    check_eq("mr_stall", o_stall, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("mr_req_drop", mem_if.req, 0);
    check_eq("mr_stall_drop", o_stall, 0);
    check_eq("mr_gp_we", o_tgt_gp_we, 0);
    check_eq("mr_result", o_result, 0);
    valid = 1'b0;
    mem_if.ack = 1'b1; mem_if.rdata = 24'h123123;
    tick();
    rst_n = 1'b1;
    mem_if.ack = 1'b0;
    tick();
    check_eq("mr_no_wb_gp_we", o_tgt_gp_we, 0);
    check_eq("mr_no_wb_result", o_result, 0);
    check_eq("mr_no_wb_req", mem_if.req, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
